// File: rtl/alu_operand_stage_pkg.sv
// alu_operand_stage_pkg: cpu_pkg holds the widths, ALU opcodes, the held-stage payload
// and the register-match helper used across the operand stage.
// No ports; imported by the interface, the top and the forwarding mux.
package cpu_pkg;
    localparam int DATA_W = 16;
    localparam int REG_AW = 3;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [REG_AW-1:0] ridx_t;
    typedef enum logic [2:0] {
        ALU_ADD     = 3'b000,
        ALU_ADD_ALT = 3'b001,
        ALU_SUB     = 3'b010,
        ALU_SUB_ALT = 3'b011,
        ALU_AND     = 3'b100,
        ALU_XOR     = 3'b101,
        ALU_OR      = 3'b110,
        ALU_OR_ALT  = 3'b111
    } alu_op_e;
    typedef struct packed {
        data_t   a;
        data_t   b;
        data_t   store;
        alu_op_e op;
        ridx_t   dst;
        logic    reg_write;
        logic    mem_read;
    } stage_t;
    // r0 is hardwired zero, so a write to it never produces a value anyone can consume.
    function automatic logic reg_match(ridx_t src, ridx_t idx, logic we);
        return we && idx != '0 && idx == src;
    endfunction
endpackage

// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if: bundle between decode, the operand stage, the ALU and the EX/MEM stage.
// Ports: none. master = decode/pipeline side driving instructions and bypass info,
// slave = operand stage producing in_ready and the registered ALU operands.
interface alu_operand_stage_if;
    import cpu_pkg::*;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_alu_op;
    ridx_t       in_rs_idx;
    ridx_t       in_rt_idx;
    data_t       in_rs_val;
    data_t       in_rt_val;
    data_t       in_imm;
    logic        in_use_imm;
    ridx_t       in_dst_idx;
    logic        in_reg_write;
    logic        in_mem_read;
    logic        flush;
    data_t       ex_result;
    ridx_t       mem_dst_idx;
    logic        mem_reg_write;
    data_t       mem_data;
    logic        out_ready;
    logic        out_valid;
    data_t       a;
    data_t       b;
    logic [2:0]  alu_op;
    data_t       store_data;
    ridx_t       out_dst_idx;
    logic        out_reg_write;
    logic        out_mem_read;
    modport master (
        output in_valid, in_alu_op, in_rs_idx, in_rt_idx, in_rs_val, in_rt_val, in_imm,
               in_use_imm, in_dst_idx, in_reg_write, in_mem_read, flush, ex_result,
               mem_dst_idx, mem_reg_write, mem_data, out_ready,
        input  in_ready, out_valid, a, b, alu_op, store_data, out_dst_idx, out_reg_write,
               out_mem_read
    );
    modport slave (
        input  in_valid, in_alu_op, in_rs_idx, in_rt_idx, in_rs_val, in_rt_val, in_imm,
               in_use_imm, in_dst_idx, in_reg_write, in_mem_read, flush, ex_result,
               mem_dst_idx, mem_reg_write, mem_data, out_ready,
        output in_ready, out_valid, a, b, alu_op, store_data, out_dst_idx, out_reg_write,
               out_mem_read
    );
endinterface

// File: rtl/alu_operand_stage_forward.sv
// operand_forward: bypass mux for one source register, EX result over MEM data over register file.
// Ports: src_i source index, rf_val_i register-file data, ex_en_i/ex_idx_i/ex_data_i held producer,
// mem_we_i/mem_idx_i/mem_data_i EX/MEM producer, val_o resolved operand.
module operand_forward
    import cpu_pkg::*;
(
    input  ridx_t src_i,
    input  data_t rf_val_i,
    input  logic  ex_en_i,
    input  ridx_t ex_idx_i,
    input  data_t ex_data_i,
    input  logic  mem_we_i,
    input  ridx_t mem_idx_i,
    input  data_t mem_data_i,
    output data_t val_o
);
    assign val_o = reg_match(src_i, ex_idx_i, ex_en_i)   ? ex_data_i  :
                   reg_match(src_i, mem_idx_i, mem_we_i) ? mem_data_i : rf_val_i;
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: decode-to-execute register resolving ALU operands with load-use stalls.
// Ports: clk_i clock, rst_i sync active-high reset, bus_io slave side of alu_operand_stage_if.
// Build option ALU_FORWARD_EN: when defined, EX/MEM results are bypassed into A/B/store data;
// when undefined, operands come straight from the register file and any pending writer stalls.
module alu_operand_stage
    import cpu_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    alu_operand_stage_if.slave bus_io
);
    logic   out_valid_q, out_valid_d;
    stage_t stage_q, stage_d;
    data_t  rs_val, rt_val;
    logic   hazard, adv, take;
`ifdef ALU_FORWARD_EN
    logic   ex_en;
    // A load's EX value is its address, not its data, so loads are never bypassed from EX.
    assign ex_en = out_valid_q && stage_q.reg_write && !stage_q.mem_read;
    operand_forward u_fwd_rs (
        .src_i(bus_io.in_rs_idx), .rf_val_i(bus_io.in_rs_val),
        .ex_en_i(ex_en), .ex_idx_i(stage_q.dst), .ex_data_i(bus_io.ex_result),
        .mem_we_i(bus_io.mem_reg_write), .mem_idx_i(bus_io.mem_dst_idx),
        .mem_data_i(bus_io.mem_data), .val_o(rs_val)
    );
    operand_forward u_fwd_rt (
        .src_i(bus_io.in_rt_idx), .rf_val_i(bus_io.in_rt_val),
        .ex_en_i(ex_en), .ex_idx_i(stage_q.dst), .ex_data_i(bus_io.ex_result),
        .mem_we_i(bus_io.mem_reg_write), .mem_idx_i(bus_io.mem_dst_idx),
        .mem_data_i(bus_io.mem_data), .val_o(rt_val)
    );
    // rt is checked even for immediate forms because the store data still needs it.
    assign hazard = bus_io.in_valid && out_valid_q && stage_q.mem_read &&
                    (reg_match(bus_io.in_rs_idx, stage_q.dst, stage_q.reg_write) ||
                     reg_match(bus_io.in_rt_idx, stage_q.dst, stage_q.reg_write));
`else
    assign rs_val = bus_io.in_rs_val;
    assign rt_val = bus_io.in_rt_val;
    // Without bypassing, wait until every pending writer has reached write-back.
    assign hazard = bus_io.in_valid &&
                    ((out_valid_q &&
                      (reg_match(bus_io.in_rs_idx, stage_q.dst, stage_q.reg_write) ||
                       reg_match(bus_io.in_rt_idx, stage_q.dst, stage_q.reg_write))) ||
                     reg_match(bus_io.in_rs_idx, bus_io.mem_dst_idx, bus_io.mem_reg_write) ||
                     reg_match(bus_io.in_rt_idx, bus_io.mem_dst_idx, bus_io.mem_reg_write));
`endif
    assign adv  = !out_valid_q || bus_io.out_ready;
    assign take = !bus_io.flush && adv && bus_io.in_valid && !hazard;
    assign out_valid_d = take || (!bus_io.flush && !adv && out_valid_q);
    always_comb begin
        stage_d = take ? '{a: rs_val, b: bus_io.in_use_imm ? bus_io.in_imm : rt_val, store: rt_val,
                           op: alu_op_e'(bus_io.in_alu_op), dst: bus_io.in_dst_idx,
                           reg_write: bus_io.in_reg_write, mem_read: bus_io.in_mem_read} : stage_q;
        stage_d.reg_write = take ? bus_io.in_reg_write : !(bus_io.flush || adv) && stage_q.reg_write;
        stage_d.mem_read  = take ? bus_io.in_mem_read  : !(bus_io.flush || adv) && stage_q.mem_read;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            stage_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            stage_q     <= stage_d;
        end
    end
    assign bus_io.in_ready      = adv && !hazard;
    assign bus_io.out_valid     = out_valid_q;
    assign bus_io.a             = stage_q.a;
    assign bus_io.b             = stage_q.b;
    assign bus_io.store_data    = stage_q.store;
    assign bus_io.alu_op        = stage_q.op;
    assign bus_io.out_dst_idx   = stage_q.dst;
    assign bus_io.out_reg_write = stage_q.reg_write;
    assign bus_io.out_mem_read  = stage_q.mem_read;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: checks operands against program-order register values from a pipeline model.
module tb_alu_operand_stage;
    import cpu_pkg::*;
    typedef struct {
        logic [2:0]  op;
        logic [2:0]  rs, rt;
        logic [15:0] imm;
        logic        ui;
        logic [2:0]  dst;
        logic        we, mr;
    } insn_t;
    typedef struct {
        logic        v;
        logic [15:0] a, b, st;
        logic [2:0]  op, dst;
        logic        we, mr;
    } held_t;
    typedef struct {
        logic        we;
        logic [2:0]  dst;
        logic [15:0] d;
    } wb_t;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    logic [15:0] arch [8];
    logic [15:0] prf [8];
    held_t h;
    wb_t m, w;
    logic acc;
    insn_t nop, ins;
    alu_operand_stage_if bus ();
    alu_operand_stage dut (.clk_i(clk), .rst_i(rst), .bus_io(bus));
    always #5 clk = ~clk;
    function automatic logic [15:0] alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            ALU_ADD, ALU_ADD_ALT: return a + b;
            ALU_SUB, ALU_SUB_ALT: return a - b;
            ALU_AND:              return a & b;
            ALU_XOR:              return a ^ b;
            default:              return a | b;
        endcase
    endfunction
    function automatic logic [15:0] result(input held_t x);
        return x.mr ? (alu(x.op, x.a, x.b) ^ 16'h00F0) : alu(x.op, x.a, x.b);
    endfunction
    function automatic logic [15:0] rd(input logic [2:0] idx);
        return idx == 0 ? 16'h0 : (w.we && w.dst == idx) ? w.d : prf[idx];
    endfunction
    function automatic logic wr(input logic we, input logic [2:0] d, input logic [2:0] s);
        return we && d != 0 && d == s;
    endfunction
    function automatic insn_t rnd_insn();
        insn_t r;
        r.op = 3'($urandom_range(0, 7));
        r.rs = 3'($urandom_range(0, 7));
        r.rt = 3'($urandom_range(0, 7));
        r.imm = 16'($urandom);
        r.ui = $urandom_range(0, 2) == 0;
        r.dst = 3'($urandom_range(0, 7));
        r.mr = $urandom_range(0, 3) == 0;
        r.we = r.mr | 1'($urandom_range(0, 1));
        return r;
    endfunction
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic step(input insn_t i, input logic vld, input logic rdy, input logic fl,
                        input logic rs_in, output logic accepted);
        logic hz, er, ret;
        logic [15:0] res;
        bus.in_valid = vld;
        bus.in_alu_op = i.op;
        bus.in_rs_idx = i.rs;
        bus.in_rt_idx = i.rt;
        bus.in_rs_val = rd(i.rs);
        bus.in_rt_val = rd(i.rt);
        bus.in_imm = i.imm;
        bus.in_use_imm = i.ui;
        bus.in_dst_idx = i.dst;
        bus.in_reg_write = i.we;
        bus.in_mem_read = i.mr;
        bus.flush = fl;
        bus.out_ready = rdy;
        rst = rs_in;
        bus.ex_result = alu(h.op, h.a, h.b);
        bus.mem_dst_idx = m.dst;
        bus.mem_reg_write = m.we;
        bus.mem_data = m.d;
`ifdef ALU_FORWARD_EN
        hz = vld && h.v && h.mr && (wr(h.we, h.dst, i.rs) || wr(h.we, h.dst, i.rt));
`else
        hz = vld && ((h.v && (wr(h.we, h.dst, i.rs) || wr(h.we, h.dst, i.rt))) ||
                     wr(m.we, m.dst, i.rs) || wr(m.we, m.dst, i.rt));
`endif
        er = (!h.v || rdy) && !hz;
        #2;
        if (!fl) chk("in_ready", 16'(bus.in_ready), 16'(er));
        @(posedge clk);
        ret = h.v && rdy && !rs_in && !fl;
        res = result(h);
        accepted = vld && er && !rs_in && !fl;
        if (w.we && w.dst != 0) prf[w.dst] = w.d;
        w = m;
        m.we = ret && h.we;
        m.dst = h.dst;
        m.d = res;
        if (ret && h.we && h.dst != 0) arch[h.dst] = res;
        if (rs_in) h = '{v: 0, a: 0, b: 0, st: 0, op: 0, dst: 0, we: 0, mr: 0};
        else if (fl) begin
            h.v = 0;
            h.we = 0;
            h.mr = 0;
        end else if (!h.v || rdy) begin
            if (accepted) h = '{v: 1, a: arch[i.rs], b: i.ui ? i.imm : arch[i.rt], st: arch[i.rt],
                                op: i.op, dst: i.dst, we: i.we, mr: i.mr};
            else begin
                h.v = 0;
                h.we = 0;
                h.mr = 0;
            end
        end
        #1;
        chk("out_valid", 16'(bus.out_valid), 16'(h.v));
        chk("a", bus.a, h.a);
        chk("b", bus.b, h.b);
        chk("store_data", bus.store_data, h.st);
        chk("alu_op", 16'(bus.alu_op), 16'(h.op));
        chk("out_dst_idx", 16'(bus.out_dst_idx), 16'(h.dst));
        chk("out_reg_write", 16'(bus.out_reg_write), 16'(h.we));
        chk("out_mem_read", 16'(bus.out_mem_read), 16'(h.mr));
    endtask
    task automatic issue(input insn_t i);
        logic a;
        a = 0;
        for (int k = 0; k < 8 && !a; k++) step(i, 1, 1, 0, 0, a);
        chk("issue_accepted", 16'(a), 16'd1);
    endtask
    task automatic idle(input int n);
        logic a;
        for (int k = 0; k < n; k++) step(nop, 0, 1, 0, 0, a);
    endtask
    initial begin
        nop = '{op: 0, rs: 0, rt: 0, imm: 0, ui: 0, dst: 0, we: 0, mr: 0};
        arch[0] = 0;
        prf[0] = 0;
        for (int k = 1; k < 8; k++) begin
            arch[k] = 16'($urandom);
            prf[k] = arch[k];
        end
        h = '{v: 0, a: 0, b: 0, st: 0, op: 0, dst: 0, we: 0, mr: 0};
        m = '{we: 0, dst: 0, d: 0};
        w = m;
        rst = 1;
        bus.in_valid = 0;
        bus.in_alu_op = 0;
        bus.in_rs_idx = 0;
        bus.in_rt_idx = 0;
        bus.in_rs_val = 0;
        bus.in_rt_val = 0;
        bus.in_imm = 0;
        bus.in_use_imm = 0;
        bus.in_dst_idx = 0;
        bus.in_reg_write = 0;
        bus.in_mem_read = 0;
        bus.flush = 0;
        bus.ex_result = 0;
        bus.mem_dst_idx = 0;
        bus.mem_reg_write = 0;
        bus.mem_data = 0;
        bus.out_ready = 1;
        @(posedge clk);
        #1;
        ins = '{op: ALU_ADD, rs: 1, rt: 2, imm: 16'h1234, ui: 0, dst: 3, we: 1, mr: 0};
        step(ins, 1, 1, 0, 1, acc);
        step(ins, 1, 1, 0, 1, acc);
        issue('{op: ALU_ADD, rs: 0, rt: 0, imm: 16'h0005, ui: 1, dst: 1, we: 1, mr: 0});
        issue('{op: ALU_SUB, rs: 1, rt: 2, imm: 0, ui: 0, dst: 3, we: 1, mr: 0});
        idle(3);
        issue('{op: ALU_ADD, rs: 0, rt: 0, imm: 16'h0000, ui: 1, dst: 2, we: 1, mr: 1});
        issue('{op: ALU_AND, rs: 3, rt: 2, imm: 0, ui: 0, dst: 4, we: 1, mr: 0});
        idle(3);
        issue('{op: ALU_ADD, rs: 0, rt: 0, imm: 16'h0007, ui: 1, dst: 0, we: 1, mr: 0});
        issue('{op: ALU_XOR, rs: 0, rt: 0, imm: 0, ui: 0, dst: 5, we: 1, mr: 0});
        idle(3);
        issue('{op: ALU_OR, rs: 4, rt: 3, imm: 0, ui: 0, dst: 6, we: 1, mr: 0});
        ins = '{op: ALU_XOR, rs: 5, rt: 7, imm: 0, ui: 0, dst: 7, we: 1, mr: 0};
        for (int k = 0; k < 3; k++) step(ins, 1, 0, 0, 0, acc);
        issue(ins);
        idle(3);
        issue('{op: ALU_SUB, rs: 6, rt: 7, imm: 0, ui: 0, dst: 1, we: 1, mr: 0});
        step('{op: ALU_ADD, rs: 2, rt: 3, imm: 0, ui: 0, dst: 2, we: 1, mr: 0}, 1, 1, 1, 0, acc);
        idle(3);
        issue('{op: ALU_ADD, rs: 1, rt: 0, imm: 16'h0010, ui: 1, dst: 3, we: 1, mr: 1});
        step('{op: ALU_AND, rs: 3, rt: 1, imm: 0, ui: 0, dst: 4, we: 1, mr: 0}, 1, 1, 0, 1, acc);
        idle(3);
        for (int k = 0; k < 500; k++)
            step(rnd_insn(), $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
                 $urandom_range(0, 30) == 0, $urandom_range(0, 40) == 0, acc);
        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Decode-to-execute pipeline register feeding the 16-bit ALU. Accepts decoded instructions over a valid/ready handshake and resolves operand A/B, with register-file values, the sign-free immediate, or forwarded results. Detects load-use hazards, inserting one bubble per stall cycle. Holds the instruction registered while the ALU computes combinationally from its outputs.

## Interface
- DATA_W, 16, operand/result width
- REG_AW, 3, register index width; index 0 is hardwired zero
- CLK  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high
- InValid  in  1  decode has an instruction
- InReady  out  1  stage accepts this cycle
- InALUOp  in  3  ALU opcode
- InRsIdx, InRtIdx  in  REG_AW  source indices
- InRsVal, InRtVal  in  DATA_W  register-file read data
- InImm  in  DATA_W  extended immediate
- InUseImm  in  1  B takes InImm instead of rt
- InDstIdx  in  REG_AW  destination index
- InRegWrite, InMemRead  in  1  control bits
- Flush  in  1  kill held instruction (branch redirect)
- ExResult  in  DATA_W  ALUOut of the instruction currently held here
- MemDstIdx  in  REG_AW, MemRegWrite  in  1, MemData  in  DATA_W  EX/MEM stage writeback info
- OutReady  in  1  downstream accepts
- OutValid  out  1  held instruction valid
- A, B  out  DATA_W  ALU operands
- ALUOp  out  3  ALU opcode
- StoreData  out  DATA_W  resolved rt value
- OutDstIdx  out  REG_AW; OutRegWrite, OutMemRead  out  1

## Operation
- advance = !OutValid || OutReady.
- Match(src, idx, we) = we && idx != 0 && idx == src.
- Hazard: InValid && OutValid && OutMemRead && (Match(InRsIdx, OutDstIdx, OutRegWrite) || Match(InRtIdx, ...)). rt is compared even when InUseImm (store data needs it).
- InReady = advance && !hazard.
- Forwarding per source (rs, rt), priority: held instruction (OutValid, OutRegWrite, !OutMemRead, match) -> ExResult; else Mem match -> MemData; else register-file value.
- A = fwd(rs); B = InUseImm ? InImm : fwd(rt); StoreData = fwd(rt).
- Register update per CLK edge, priority: Reset > Flush > advance.
  - Reset: OutValid=0, A=B=StoreData=0, ALUOp=0, OutDstIdx=0, OutRegWrite=OutMemRead=0.
  - Flush: OutValid=0, OutRegWrite=OutMemRead=0; an incoming instruction is not accepted (InReady is irrelevant that cycle, the decoder is also flushed).
  - advance: OutValid <= InValid && !hazard; payload loads only when InValid && !hazard; a bubble clears OutRegWrite and OutMemRead.
  - else hold all registers.
- Register-file writes are write-before-read; WB stage needs no forwarding.

## Timing
- Latency: 1 cycle from accepted input to OutValid.
- Throughput: 1/cycle with no hazard and OutReady=1.
- Load-use: exactly one bubble; next cycle the load is in MEM and is forwarded from MemData.
- OutReady=0 with OutValid=1: outputs stable, InReady=0.
- Reset mid-stall or mid-transfer: instruction discarded, outputs per reset values next cycle.
- Simultaneous Ex and Mem match: Ex wins.

## Configuration
- ALU_FORWARD_EN defined: forwarding as above.
- Undefined: forwarding muxes are removed, and operands always come from InRsVal/InRtVal. The hazard condition becomes any match against the held instruction (OutRegWrite) or the Mem stage (MemRegWrite), regardless of OutMemRead. Bubbles are inserted until the producer has passed WB.

## Structure
- Shared package cpu_pkg: DATA_W, REG_AW, ALUOp encodings (ADD 000/001, SUB 010/011, AND 100, XOR 101, OR 110/111).
- Sub-module operand_forward: a single source's match/priority mux, instantiated for rs and rt; compiled out without ALU_FORWARD_EN.

## Test plan
- Reset asserted with InValid=1 -> OutValid=0, A=B=0 next cycle; first accepted instruction appears 1 cycle after release.
- Test: producer ADD r1 (ExResult=0x0005) followed by SUB using rs=r1, InRsVal=0x0000 -> A=0x0005; without ALU_FORWARD_EN, one bubble per cycle until r1 has retired.
- Test: load to r2 followed by AND using rt=r2 -> InReady=0 for one cycle, one bubble (OutValid=0); the next cycle B=MemData=0x00F0.
- Test: dst r0 with RegWrite, consumer rs=r0, InRsVal=0 -> no forward, no stall, A=0x0000.
- Test: OutReady=0 for 3 cycles with valid held -> outputs unchanged, InReady=0; OutReady=1 -> next instruction loads.
- Test: Flush with InValid=1 and OutValid=1 -> OutValid=0 next cycle, OutRegWrite=0, input not captured.
